// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised FIFO.
package fifo_pkg;

  // Read-mode selectors for the FWFT parameter.
  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
// Reads return the old contents when the same address is written on the same edge.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port and registered read port share one clocked process.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with wrap-bit pointers, registered status flags, sticky
// error flags and a selectable registered-read or first-word-fall-through port.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2,
  parameter int FWFT      = FWFT_OFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     write_en,
  input  logic                     read_en,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        data_out,
  output logic                     read_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4) ||
      (AF_MARGIN >= DEPTH) || (AE_MARGIN >= DEPTH)) begin : g_param_check
    $error("param_fifo: DEPTH must be a power of two >= 4 and margins < DEPTH");
  end

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              af_q, af_d, ae_q, ae_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              rvalid_q, rvalid_d;
  logic              loaded_q, loaded_d;   // data_out has been given real data since reset
  logic              byp_sel_q, byp_sel_d; // head word was written on the last edge
  logic [DATA_W-1:0] byp_data_q, byp_data_d;
  logic              wr_accept, rd_accept;
  logic              ram_wr_en, ram_rd_en;
  logic [AW-1:0]     ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;

  // Accept decisions, next pointers, next flags and mode-specific read control.
  always_comb begin
    rd_accept  = read_en && !empty_q;
    wr_accept  = write_en && (!full_q || rd_accept);
    ram_wr_en  = wr_accept && rst_n;
    wr_ptr_d   = wr_ptr_q + PW'(wr_accept);
    rd_ptr_d   = rd_ptr_q + PW'(rd_accept);
    count_d    = count_q;
    if (wr_accept && !rd_accept) count_d = count_q + 1'b1;
    if (rd_accept && !wr_accept) count_d = count_q - 1'b1;
    empty_d    = (wr_ptr_d == rd_ptr_d);
    full_d     = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]);
    af_d       = (count_d >= PW'(DEPTH - AF_MARGIN));
    ae_d       = (count_d <= PW'(AE_MARGIN));
    ovf_d      = (ovf_q && !clr_err) || (write_en && !wr_accept);
    udf_d      = (udf_q && !clr_err) || (read_en && empty_q);
    byp_data_d = data_in;
    if (FWFT == FWFT_ON) begin
      // Keep the RAM pointed at the next head; forward a word written straight into it.
      ram_rd_en   = 1'b1;
      ram_rd_addr = rd_ptr_d[AW-1:0];
      byp_sel_d   = wr_accept && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]);
      loaded_d    = loaded_q || wr_accept;
      rvalid_d    = !empty_d;
    end else begin
      // Only fetch on an accepted pop so data_out holds between reads.
      ram_rd_en   = rd_accept;
      ram_rd_addr = rd_ptr_q[AW-1:0];
      byp_sel_d   = 1'b0;
      loaded_d    = loaded_q || rd_accept;
      rvalid_d    = rd_accept;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      loaded_q   <= 1'b0;
      byp_sel_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rvalid_q   <= rvalid_d;
      loaded_q   <= loaded_d;
      byp_sel_q  <= byp_sel_d;
      byp_data_q <= byp_data_d;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (data_in),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  assign data_out     = !loaded_q ? '0 : (byp_sel_q ? byp_data_q : ram_rd_data);
  assign read_valid   = rvalid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed + random bench driving a registered-read and an FWFT instance with
// identical stimulus, checked against a queue model and a popped-word scoreboard.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       write_en, read_en, clr_err;

  logic [7:0] data_out0, data_out1;
  logic       read_valid0, read_valid1, full0, full1, empty0, empty1;
  logic       af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;
  logic [3:0] count0, count1;

  int         checks = 0;
  int         failures = 0;
  int         txn = 0;
  logic [7:0] mq[$];    // model contents, head at index 0
  logic [7:0] rdq[$];   // words expected on the registered-read port
  bit         m_ovf, m_udf;
  logic [7:0] last0;    // value data_out0 must be holding

  always #5 clk = ~clk;

  param_fifo #(.DATA_W(8), .DEPTH(8), .AF_MARGIN(2), .AE_MARGIN(2), .FWFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .write_en(write_en), .read_en(read_en),
    .clr_err(clr_err), .data_out(data_out0), .read_valid(read_valid0), .full(full0),
    .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0));

  param_fifo #(.DATA_W(8), .DEPTH(8), .AF_MARGIN(2), .AE_MARGIN(2), .FWFT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .write_en(write_en), .read_en(read_en),
    .clr_err(clr_err), .data_out(data_out1), .read_valid(read_valid1), .full(full1),
    .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the model after an edge.
  task automatic check_all(input bit popped);
    int n;
    logic [7:0] e;
    n = mq.size();
    chk("count0", count0, n);          chk("count1", count1, n);
    chk("full0", full0, n == 8);       chk("full1", full1, n == 8);
    chk("empty0", empty0, n == 0);     chk("empty1", empty1, n == 0);
    chk("afull0", af0, n >= 6);        chk("afull1", af1, n >= 6);
    chk("aempty0", ae0, n <= 2);       chk("aempty1", ae1, n <= 2);
    chk("ovf0", ovf0, m_ovf);          chk("ovf1", ovf1, m_ovf);
    chk("udf0", udf0, m_udf);          chk("udf1", udf1, m_udf);
    chk("rvalid0", read_valid0, popped);
    if (popped) begin
      e = rdq.pop_front();
      chk("dout0", data_out0, e);
      last0 = e;
    end else begin
      chk("hold0", data_out0, last0);
    end
    chk("rvalid1", read_valid1, n > 0);
    if (n > 0) chk("head1", data_out1, mq[0]);
  endtask

  // One clock of stimulus: update model, drive, step, compare.
  task automatic cyc(input bit we, input bit re, input bit clr, input logic [7:0] d);
    bit wa, ra;
    int n;
    n  = mq.size();
    ra = re && (n > 0);
    wa = we && ((n < 8) || ra);
    m_ovf = (m_ovf && !clr) || (we && !wa);
    m_udf = (m_udf && !clr) || (re && (n == 0));
    if (ra) rdq.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    write_en = we; read_en = re; clr_err = clr; data_in = d;
    @(posedge clk); #1;
    write_en = 1'b0; read_en = 1'b0; clr_err = 1'b0;
    txn++;
    $display("txn %0d we=%0b re=%0b clr=%0b d=%02h count=%0d dout0=%02h dout1=%02h",
             txn, we, re, clr, d, count0, data_out0, data_out1);
    check_all(ra);
  endtask

  // Reset with live requests on the bus; they must be ignored.
  task automatic do_reset();
    rst_n = 1'b0; write_en = 1'b1; read_en = 1'b1; clr_err = 1'b0; data_in = 8'h5A;
    @(posedge clk); #1;
    mq.delete(); rdq.delete(); m_ovf = 0; m_udf = 0; last0 = 8'h00;
    txn++;
    $display("txn %0d reset count=%0d", txn, count0);
    check_all(1'b0);
    chk("rst_dout1", data_out1, 8'h00);
    rst_n = 1'b1; write_en = 1'b0; read_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; write_en = 1'b0; read_en = 1'b0; clr_err = 1'b0; data_in = 8'h00;
    m_ovf = 0; m_udf = 0; last0 = 8'h00;
    do_reset();
    do_reset();

    // Underflow on empty after reset, then clear.
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 1, 8'h00);

    // Write 0..7 then read 8 back in order.
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 8'(i));
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 8'h00);

    // Overflow: fill, push 0xAA, clear; clear coincident with new error keeps flag.
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 8'(8'h30 + i));
    cyc(1, 0, 0, 8'hAA);
    cyc(0, 0, 1, 8'h00);
    cyc(1, 0, 1, 8'hAB);
    cyc(0, 0, 1, 8'h00);

    // Full with simultaneous write and read for 4 cycles, then drain.
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 8'(8'h50 + i));
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 8'h00);

    // Empty with write and read together: write only, underflow set.
    cyc(1, 1, 0, 8'h77);
    cyc(0, 1, 1, 8'h00);

    // 20 writes / 20 reads interleaved across pointer wraps.
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'(8'h80 + i));
    for (int i = 6; i < 20; i++) cyc(1, 1, 0, 8'(8'h80 + i));
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 8'h00);

    // Random traffic against the model.
    for (int i = 0; i < 80; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 7) == 0, 8'($urandom));
    while (mq.size() > 0) cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 1, 8'h00);

    // FWFT head visible without read_en; reset mid-stream with 5 words.
    cyc(1, 0, 0, 8'h11);
    cyc(0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'(8'h12 + i));
    do_reset();
    cyc(1, 0, 0, 8'hC3);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
